// File: rtl/exe_wb_arbiter_if.sv
// Execute-to-writeback bus: four unit requests in, one registered writeback out.
// The arbiter takes the slave view; requesters and the writeback consumer take the master view.
interface exe_wb_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
);
  logic                        kill_i;
  logic [3:0]                  req_valid_i;
  logic [3:0][REG_W-1:0]       req_rd_i;
  logic [3:0][DATA_W-1:0]      req_data_i;
  logic [3:0]                  gnt_o;
  logic                        wb_valid_o;
  logic [REG_W-1:0]            wb_rd_o;
  logic [DATA_W-1:0]           wb_data_o;
  logic [1:0]                  wb_src_o;
  logic                        wb_ready_i;
  logic                        stall_o;

  modport slave (
    input  kill_i, req_valid_i, req_rd_i, req_data_i, wb_ready_i,
    output gnt_o, wb_valid_o, wb_rd_o, wb_data_o, wb_src_o, stall_o
  );

  modport master (
    output kill_i, req_valid_i, req_rd_i, req_data_i, wb_ready_i,
    input  gnt_o, wb_valid_o, wb_rd_o, wb_data_o, wb_src_o, stall_o
  );
endinterface

// File: rtl/exe_wb_arbiter.sv
// Four-unit writeback arbiter with a one-entry output register (EMPTY/FULL).
// Fixed priority MEM > DIV > MUL > ALU by default; define WB_ARB_RR_EN for round-robin.
module exe_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input logic clk_i,
  input logic rst_i,
  exe_wb_arbiter_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_e;

  state_e              state_q;
  logic [REG_W-1:0]    wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [1:0]          wb_src_q;
  logic [3:0]          gnt;
  logic [1:0]          gnt_idx;
  logic                req_found;
  logic                can_accept;
  logic                accept;

  // The slot can take a new result when empty or draining this cycle.
  assign can_accept = (state_q == EMPTY || bus.wb_ready_i) && !bus.kill_i && !rst_i;

`ifdef WB_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] rot_req;

  // rot_req[gi] is the unit gi positions after the pointer.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign rot_req[gi] = bus.req_valid_i[ptr_q + 2'(gi)];
  end

  always_comb begin
    req_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < 4; i++) begin
      if (!req_found && rot_req[i]) begin
        req_found = 1'b1;
        gnt_idx   = ptr_q + 2'(i);
      end
    end
  end

  assign ptr_d = gnt_idx + 2'd1;
`else
  // Later iterations overwrite earlier ones, so the highest index wins.
  always_comb begin
    req_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < 4; i++) begin
      if (bus.req_valid_i[i]) begin
        req_found = 1'b1;
        gnt_idx   = 2'(i);
      end
    end
  end
`endif

  always_comb begin
    gnt = '0;
    if (req_found && can_accept) gnt[gnt_idx] = 1'b1;
  end

  assign accept    = |gnt;
  assign wb_rd_d   = bus.req_rd_i[gnt_idx];
  assign wb_data_d = bus.req_data_i[gnt_idx];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= EMPTY;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      wb_src_q  <= '0;
`ifdef WB_ARB_RR_EN
      ptr_q     <= '0;
`endif
    end else if (bus.kill_i) begin
      state_q <= EMPTY;
    end else if (accept) begin
      state_q   <= FULL;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      wb_src_q  <= gnt_idx;
`ifdef WB_ARB_RR_EN
      ptr_q     <= ptr_d;
`endif
    end else if (state_q == FULL && bus.wb_ready_i) begin
      state_q <= EMPTY;
    end
  end

  assign bus.gnt_o      = gnt;
  assign bus.stall_o    = |(bus.req_valid_i & ~gnt);
  assign bus.wb_valid_o = (state_q == FULL);
  assign bus.wb_rd_o    = wb_rd_q;
  assign bus.wb_data_o  = wb_data_q;
  assign bus.wb_src_o   = wb_src_q;
endmodule
